rng_arbiter: RTL and testbench
==============================

RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the generator.
REQ-002 Parameter WARM, default 4, number of LFSR steps with no grants after each seed load.
REQ-003 Parameter TAPS, default 8'hB8, Galois feedback mask (maximal, period 255).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 seed_load  in  1  one-cycle pulse that loads seed.
REQ-007 seed  in  8  seed value, sampled when seed_load=1.
REQ-008 req  in  NREQ  per-requester request, level, held until its gnt is seen.
REQ-009 gnt  out  NREQ  registered one-hot grant, one-cycle pulse.
REQ-010 rnd  out  8  random value for the granted requester, valid only with rnd_valid.
REQ-011 rnd_valid  out  1  high exactly when gnt is nonzero.
REQ-012 busy  out  1  high in S_IDLE and S_WARM.
REQ-013 wrap  out  1  one-cycle pulse at the end of each full LFSR period.
REQ-014 period_err  out  1  sticky period-check failure flag.

Function
REQ-015 LFSR step SHALL be next = (s >> 1) ^ (s[0] ? TAPS : 8'h00).
REQ-016 A loaded seed of 8'h00 SHALL be replaced by 8'h01.
REQ-017 FSM states SHALL be S_IDLE, S_WARM and S_RUN, with no grants outside S_RUN.
REQ-018 S_IDLE SHALL hold the LFSR and move to S_WARM on seed_load.
REQ-019 S_WARM SHALL step the LFSR once per cycle for WARM cycles, then move to S_RUN.
REQ-020 seed_load in any state SHALL reload the LFSR, zero the step count, and enter S_WARM next cycle, with no grant issued for that cycle.
REQ-021 seed_load SHALL have priority over a simultaneous req.
REQ-022 S_RUN arbitration SHALL be round-robin:
- search starts at ptr;
- the winner w is granted;
- ptr <= (w+1) mod NREQ.
REQ-023 The requester whose gnt is high in the current cycle SHALL be excluded from arbitration in that cycle.
REQ-024 Grant latency SHALL be one cycle: req sampled at edge N gives gnt/rnd/rnd_valid after edge N, with rnd equal to the LFSR state before edge N.
REQ-025 The LFSR SHALL step only on a grant in S_RUN (and every cycle in S_WARM), so no value repeats within 255 steps.
REQ-026 With no req in S_RUN, the LFSR SHALL hold and gnt=0.
REQ-027 rnd SHALL read 8'h00 whenever rnd_valid=0.

Reset
REQ-028 While reset=0 at a clock edge, the block SHALL:
- enter S_IDLE;
- set the LFSR to 8'h01 and ptr to 0;
- set gnt=0, rnd=0, rnd_valid=0, busy=1, wrap=0, period_err=0.
REQ-029 Reset mid-grant SHALL drop gnt on the next cycle, with no partial handshake retained.

Configuration
REQ-030 With RNG_ARB_PERIOD_CHK_EN defined, the block SHALL:
- keep an 8-bit step counter since seed load;
- pulse wrap when the counter reaches 255, then restart the counter at 0;
- set period_err if the state equals the loaded seed at any other count, or differs from it at count 255.
REQ-031 Without RNG_ARB_PERIOD_CHK_EN, the counter SHALL be absent and wrap and period_err tied to 0.
REQ-032 period_err SHALL clear only on reset or seed_load.

Structure
REQ-033 Package rng_pkg SHALL hold the FSM state typedef, the default TAPS and WARM constants, and the 8'h01 zero-seed substitute.
REQ-034 Sub-module lfsr8_core SHALL hold the 8-bit register with synchronous load/step enables and the REQ-015 step.
REQ-035 The FSM, arbiter and period checker SHALL reside in rng_arbiter.

Verification
REQ-036 Reset, seed_load seed=8'h01, req=0 -> busy=1 for 4 cycles; after req[0] rises, first grant gives rnd=8'h17, next grant rnd=8'hB3.
REQ-037 req=4'b0001 held -> gnt[0] every other cycle (mask), rnd values distinct, no back-to-back grant.
REQ-038 req=4'b1111 held in S_RUN from ptr=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001, one per cycle.
REQ-039 seed=8'h00 loaded -> identical sequence to seed=8'h01 (first rnd 8'h17).
REQ-040 Macro defined, req=4'b1111 continuous after seed 8'h5A -> wrap pulses exactly 255 steps after load; period_err stays 0.
REQ-041 seed_load with req=4'b0010 in S_RUN -> no gnt next cycle, busy=1 for 4 cycles; reset=0 mid-grant -> gnt=0, rnd=0 next cycle.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and constants for the round-robin RNG arbiter slice.
package rng_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARM,
        S_RUN
    } state_t;

    localparam logic [7:0] TAPS_DEF      = 8'hB8;
    localparam int unsigned WARM_DEF     = 4;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

    // One Galois step: shift right, fold the feedback mask in when bit 0 falls out.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] taps);
        return (s >> 1) ^ (s[0] ? taps : 8'h00);
    endfunction

endpackage

// File: rtl/lfsr8_core.sv
// 8-bit Galois LFSR register with synchronous load and step enables (load wins).
module lfsr8_core
    import rng_pkg::*;
#(
    parameter logic [7:0] TAPS = TAPS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       step,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= ZERO_SEED_SUB;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= lfsr_next(q, TAPS);
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter handing out one LFSR value per grant, with seed warm-up.
// Optional period checker enabled by defining RNG_ARB_PERIOD_CHK_EN.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned WARM = WARM_DEF,
    parameter logic [7:0]  TAPS = TAPS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            seed_load,
    input  logic [7:0]      seed,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [7:0]      rnd,
    output logic            rnd_valid,
    output logic            busy,
    output logic            wrap,
    output logic            period_err
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WW = $clog2(WARM + 1);

    state_t          state, state_d;
    logic [PW-1:0]   ptr, ptr_d;
    logic [WW-1:0]   warm_cnt;
    logic [7:0]      lfsr_q;
    logic [7:0]      eff_seed;
    logic            lfsr_load, lfsr_step, arb_en, grant_en;
    logic            found;
    int unsigned     idx, win_idx;
    logic [NREQ-1:0] avail, gnt_d;

    assign eff_seed = (seed == 8'h00) ? ZERO_SEED_SUB : seed;
    assign busy     = (state != S_RUN);

    lfsr8_core #(.TAPS(TAPS)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val (eff_seed),
        .step     (lfsr_step),
        .q        (lfsr_q)
    );

    // The requester currently holding gnt is masked so it cannot win twice in a row.
    always_comb begin
        avail   = req & ~gnt;
        found   = 1'b0;
        idx     = 0;
        win_idx = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!found && avail[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
        gnt_d = '0;
        if (found) gnt_d[win_idx] = 1'b1;
        ptr_d = PW'((win_idx + 1) % NREQ);
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        arb_en    = 1'b0;
        if (seed_load) begin
            lfsr_load = 1'b1;
            state_d   = S_WARM;
        end else begin
            case (state)
                S_IDLE: state_d = S_IDLE;
                S_WARM: begin
                    lfsr_step = 1'b1;
                    if (warm_cnt == WW'(WARM - 1)) state_d = S_RUN;
                end
                S_RUN: begin
                    arb_en    = 1'b1;
                    lfsr_step = found;
                end
                default: state_d = S_IDLE;
            endcase
        end
        grant_en = arb_en && found;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr       <= '0;
            gnt       <= '0;
            rnd       <= '0;
            rnd_valid <= 1'b0;
            warm_cnt  <= '0;
        end else begin
            gnt       <= grant_en ? gnt_d : '0;
            rnd       <= grant_en ? lfsr_q : '0;
            rnd_valid <= grant_en;
            if (grant_en) ptr <= ptr_d;
            if (lfsr_load)           warm_cnt <= '0;
            else if (state == S_WARM) warm_cnt <= warm_cnt + WW'(1);
        end
    end

`ifdef RNG_ARB_PERIOD_CHK_EN
    logic [7:0] step_cnt;
    logic [7:0] seed_ref;
    logic [7:0] lfsr_n;

    assign lfsr_n = lfsr_next(lfsr_q, TAPS);

    // Count 254 -> 0 is the 255th step: the state must be back at the seed there and nowhere else.
    always_ff @(posedge clk) begin
        if (!reset) begin
            step_cnt   <= '0;
            seed_ref   <= ZERO_SEED_SUB;
            wrap       <= 1'b0;
            period_err <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (seed_load) begin
                step_cnt   <= '0;
                seed_ref   <= eff_seed;
                period_err <= 1'b0;
            end else if (lfsr_step) begin
                if (step_cnt == 8'd254) begin
                    step_cnt <= '0;
                    wrap     <= 1'b1;
                    if (lfsr_n != seed_ref) period_err <= 1'b1;
                end else begin
                    step_cnt <= step_cnt + 8'd1;
                    if (lfsr_n == seed_ref) period_err <= 1'b1;
                end
            end
        end
    end
`else
    assign wrap       = 1'b0;
    assign period_err = 1'b0;
`endif

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter: directed scenarios plus randomized traffic
// against an orbit-table reference model.
module tb_rng_arbiter;

    localparam int         NREQ = 4;
    localparam int         WARM = 4;
    localparam logic [7:0] TAPS = 8'hB8;

    logic            clk = 1'b0;
    logic            reset;
    logic            seed_load;
    logic [7:0]      seed;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [7:0]      rnd;
    logic            rnd_valid;
    logic            busy;
    logic            wrap;
    logic            period_err;

    always #5 clk = ~clk;

    rng_arbiter #(.NREQ(NREQ), .WARM(WARM), .TAPS(TAPS)) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed       (seed),
        .req        (req),
        .gnt        (gnt),
        .rnd        (rnd),
        .rnd_valid  (rnd_valid),
        .busy       (busy),
        .wrap       (wrap),
        .period_err (period_err)
    );

    int vecs = 0;
    int errs = 0;

    // Reference: the LFSR is a walk around a fixed 255-entry orbit.
    logic [7:0] orbit [255];
    int         posof [256];

    bit         m_seeded;
    int         m_warm_left;
    logic [7:0] m_lfsr;
    int         m_ptr;
    int         m_gnt;
    logic [7:0] m_rnd;
    int         m_steps;
    bit         m_wrap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic advance();
        m_lfsr = orbit[(posof[m_lfsr] + 1) % 255];
        m_steps++;
        if (m_steps == 255) begin
            m_wrap  = 1'b1;
            m_steps = 0;
        end
    endtask

    task automatic model_edge();
        int w;
        if (!reset) begin
            m_seeded = 0; m_warm_left = 0; m_lfsr = 8'h01; m_ptr = 0;
            m_gnt = -1; m_rnd = 8'h00; m_steps = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            w = -1;
            m_rnd = 8'h00;
            if (seed_load) begin
                m_lfsr      = (seed == 8'h00) ? 8'h01 : seed;
                m_seeded    = 1;
                m_warm_left = WARM;
                m_steps     = 0;
            end else if (m_seeded && m_warm_left > 0) begin
                advance();
                m_warm_left--;
            end else if (m_seeded) begin
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (w < 0 && req[i] && i != m_gnt) w = i;
                end
                if (w >= 0) begin
                    m_rnd = m_lfsr;
                    m_ptr = (w + 1) % NREQ;
                    advance();
                end
            end
            m_gnt = w;
        end
    endtask

    task automatic compare_all();
        check("gnt", 32'(gnt), (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt));
        check("rnd", 32'(rnd), 32'(m_rnd));
        check("rnd_valid", 32'(rnd_valid), (m_gnt >= 0) ? 32'd1 : 32'd0);
        check("busy", 32'(busy), (!m_seeded || m_warm_left > 0) ? 32'd1 : 32'd0);
`ifdef RNG_ARB_PERIOD_CHK_EN
        check("wrap", 32'(wrap), 32'(m_wrap));
`else
        check("wrap", 32'(wrap), 32'd0);
`endif
        check("period_err", 32'(period_err), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic load_seed(input logic [7:0] s);
        seed_load = 1'b1;
        seed      = s;
        tick();
        seed_load = 1'b0;
    endtask

    initial begin
        logic [7:0] s;
        logic [3:0] exp_seq [5];
        s = 8'h01;
        for (int k = 0; k < 255; k++) begin
            orbit[k] = s;
            posof[s] = k;
            s = (s >> 1) ^ (s[0] ? TAPS : 8'h00);
        end
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;

        reset = 1'b0; seed_load = 1'b0; seed = 8'h00; req = '0;
        #1;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rnd", 32'(rnd), 32'd0);

        // Warm-up after seed 01, then first two grants to requester 0.
        reset = 1'b1;
        load_seed(8'h01);
        check("warm_busy0", 32'(busy), 32'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("warm_busy", 32'(busy), 32'd1);
        end
        tick();
        check("run_busy", 32'(busy), 32'd0);
        req = 4'b0001;
        tick();
        check("first_gnt", 32'(gnt), 32'd1);
        check("first_rnd", 32'(rnd), 32'h17);
        tick();
        check("masked_gnt", 32'(gnt), 32'd0);
        tick();
        check("second_rnd", 32'(rnd), 32'hB3);
        tick();
        req = '0;

        // Full rotation from ptr 0 with all requesters active.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        load_seed(8'h01);
        repeat (4) tick();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_seq", 32'(gnt), 32'(exp_seq[k]));
        end

        // seed_load beats a pending request; then reset mid-grant.
        req = 4'b0010;
        load_seed(8'h33);
        check("sl_nognt", 32'(gnt), 32'd0);
        check("sl_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        check("sl_busy3", 32'(busy), 32'd1);
        tick();
        check("sl_run", 32'(busy), 32'd0);
        tick();
        check("sl_gnt", 32'(gnt), 32'b0010);
        reset = 1'b0;
        tick();
        check("rst_mid_gnt", 32'(gnt), 32'd0);
        check("rst_mid_rnd", 32'(rnd), 32'd0);
        reset = 1'b1;
        req = '0;

        // Zero seed behaves as seed 01.
        load_seed(8'h00);
        repeat (4) tick();
        req = 4'b0001;
        tick();
        check("zero_seed_rnd", 32'(rnd), 32'h17);
        req = '0;
        tick();

        // Full period from seed 5A: 4 warm steps + 251 grants.
        load_seed(8'h5A);
        req = 4'b1111;
        repeat (4) tick();
        repeat (251) tick();
`ifdef RNG_ARB_PERIOD_CHK_EN
        check("wrap_255", 32'(wrap), 32'd1);
`endif
        tick();
        check("period_rnd", 32'(rnd), 32'h5A);
        req = '0;

        // Randomized traffic with occasional reloads and resets.
        for (int n = 0; n < 1500; n++) begin
            req       = 4'($urandom);
            seed_load = ($urandom_range(0, 39) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            reset     = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset = 1'b1; seed_load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
